// File: rtl/fft_r22sdf_ctrl_if.sv
// Sample-stream and output-framing signals between the radix-2^2 SDF frame sequencer and its
// surroundings. The sequencer takes the slave side.
interface fft_r22sdf_ctrl_if #(
  parameter int unsigned FFT_NLOG2 = 10
);
  logic                 en_i;
  logic                 valid_i;
  logic                 ready_o;
  logic                 zero_o;
  logic [FFT_NLOG2-1:0] cnt_o;
  logic                 valid_o;
  logic                 sof_o;
  logic                 eof_o;
  logic [FFT_NLOG2-1:0] out_idx_o;
  logic                 busy_o;
  logic                 err_o;
  logic                 err_clr_i;

  modport master (
    output en_i, valid_i, err_clr_i,
    input  ready_o, zero_o, cnt_o, valid_o, sof_o, eof_o, out_idx_o, busy_o, err_o
  );

  modport slave (
    input  en_i, valid_i, err_clr_i,
    output ready_o, zero_o, cnt_o, valid_o, sof_o, eof_o, out_idx_o, busy_o, err_o
  );
endinterface

// File: rtl/fft_r22sdf_ctrl.sv
// Frame sequencer for the radix-2^2 SDF FFT pipeline: drives slot counter and input zero-mux,
// zero-pads short frames, drains in-flight frames and frames the pipeline output.
module fft_r22sdf_ctrl #(
  parameter int unsigned FFT_N     = 1024,
  parameter int unsigned FFT_NLOG2 = 10,
  parameter int unsigned LATENCY   = 1033,
  parameter int unsigned PEND_W    = 4
) (
  input logic              clk_i,
  input logic              rst_n_i,
  fft_r22sdf_ctrl_if.slave bus_io
);
  localparam int unsigned DlyW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [FFT_NLOG2-1:0] CntMax  = FFT_NLOG2'(FFT_N - 1);
  localparam logic [FFT_NLOG2-1:0] CntOne  = FFT_NLOG2'(1);
  localparam logic [DlyW-1:0]      DlyLoad = DlyW'(LATENCY - 1);
  localparam logic [DlyW-1:0]      DlyOne  = DlyW'(1);
  localparam logic [PEND_W-1:0]    PendOne = PEND_W'(1);

  typedef enum logic [1:0] {StIdle, StRun, StPad, StDrain} state_e;

  state_e               state_q, state_d;
  logic [FFT_NLOG2-1:0] cnt_q, cnt_d;
  logic [FFT_NLOG2-1:0] ocnt_q, ocnt_d;
  logic [FFT_NLOG2-1:0] idx_q, idx_d;
  logic [PEND_W-1:0]    pend_q, pend_d;
  logic [DlyW-1:0]      dly_q, dly_d;
  logic                 valid_q, valid_d, sof_q, sof_d, eof_q, eof_d;
  logic                 busy_q, busy_d, err_q, err_d;
  logic                 ready, acc, inc, run, dec;

  assign ready = (state_q == StIdle) || (state_q == StRun);
  assign acc   = bus_io.valid_i & bus_io.en_i & ready;
  // Output side is live once the initial latency has elapsed and a frame is still owed.
  assign run   = (dly_q == '0) && (pend_q != '0);
  assign dec   = run && (ocnt_q == CntMax);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntOne;
    err_d   = err_q & ~bus_io.err_clr_i;
    inc     = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (acc) begin
          inc     = 1'b1;
          cnt_d   = CntOne;
          state_d = StRun;
        end
      end
      StRun: begin
        if (acc) begin
          inc = (cnt_q == '0);
        end else if (cnt_q == '0) begin
          state_d = StDrain;
        end else begin
          err_d   = 1'b1;
          state_d = StPad;
        end
      end
      StPad: begin
        if (cnt_q == CntMax) state_d = StDrain;
      end
      StDrain: begin
        if (dec && (pend_q == PendOne)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    dly_d = dly_q;
    if ((state_q == StIdle) && acc) dly_d = DlyLoad;
    else if (dly_q != '0)           dly_d = dly_q - DlyOne;

    unique case ({inc, dec})
      2'b10:   pend_d = pend_q + PendOne;
      2'b01:   pend_d = pend_q - PendOne;
      default: pend_d = pend_q;
    endcase

    ocnt_d  = run ? ocnt_q + CntOne : ocnt_q;
    // Registered outputs are derived from next-state so they line up with the slot they describe.
    valid_d = (dly_d == '0) && (pend_d != '0);
    sof_d   = valid_d && (ocnt_d == '0);
    eof_d   = valid_d && (ocnt_d == CntMax);
    idx_d   = '0;
    for (int unsigned i = 0; i < FFT_NLOG2; i++) idx_d[i] = ocnt_d[FFT_NLOG2-1-i];
    busy_d  = (state_q != StIdle) || (pend_q != '0);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ocnt_q  <= '0;
      idx_q   <= '0;
      pend_q  <= '0;
      dly_q   <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ocnt_q  <= ocnt_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      dly_q   <= dly_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign bus_io.ready_o   = ready;
  assign bus_io.zero_o    = ~acc;
  assign bus_io.cnt_o     = cnt_q;
  assign bus_io.valid_o   = valid_q;
  assign bus_io.sof_o     = sof_q;
  assign bus_io.eof_o     = eof_q;
  assign bus_io.out_idx_o = idx_q;
  assign bus_io.busy_o    = busy_q;
  assign bus_io.err_o     = err_q;
endmodule

// File: tb/tb_fft_r22sdf_ctrl.sv
// Scoreboard bench for fft_r22sdf_ctrl with N=16, LATENCY=20: stimulus queues expected output
// samples, a negedge monitor pops and compares them whenever valid_o is high.
module tb_fft_r22sdf_ctrl;
  localparam int unsigned N   = 16;
  localparam int unsigned LOG = 4;
  localparam int unsigned LAT = 20;

  typedef struct {
    int unsigned cyc;
    logic        sof;
    logic        eof;
    logic [3:0]  idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned base;
  exp_t        exp_q[$];
  logic [3:0]  brev_tab [16] = '{4'd0, 4'd8, 4'd4, 4'd12, 4'd2, 4'd10, 4'd6, 4'd14,
                                 4'd1, 4'd9, 4'd5, 4'd13, 4'd3, 4'd11, 4'd7, 4'd15};

  fft_r22sdf_ctrl_if #(.FFT_NLOG2(LOG)) bus ();

  fft_r22sdf_ctrl #(
    .FFT_N    (N),
    .FFT_NLOG2(LOG),
    .LATENCY  (LAT),
    .PEND_W   (4)
  ) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus_io (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_frame(input int unsigned start, input int unsigned n);
    exp_t e;
    for (int k = 0; k < int'(n); k++) begin
      e.cyc = start + k;
      e.sof = (k == 0);
      e.eof = (k == N - 1);
      e.idx = brev_tab[k];
      exp_q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drained(input string name);
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.valid_o) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: got valid_o=1, expected no output (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("out_cycle", cyc, e.cyc);
        chk("out_sof", bus.sof_o, e.sof);
        chk("out_eof", bus.eof_o, e.eof);
        chk("out_idx", bus.out_idx_o, e.idx);
      end
    end else if (bus.sof_o || bus.eof_o) begin
      chk("sof_eof_without_valid", {bus.sof_o, bus.eof_o}, 0);
    end
  end

  initial begin
    bus.en_i      = 1'b1;
    bus.valid_i   = 1'b0;
    bus.err_clr_i = 1'b0;
    rst_n         = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_ready", bus.ready_o, 1);
    chk("rst_zero", bus.zero_o, 1);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_err", bus.err_o, 0);
    chk("rst_cnt", bus.cnt_o, 0);
    step();
    rst_n = 1'b1;
    step();

    // 1: single frame
    base = cyc;
    for (int t = 0; t < 40; t++) begin
      bus.valid_i = (t <= 15);
      if (t == 0) push_frame(base + LAT, 16);
      @(negedge clk);
      if (t == 0) begin chk("t1_cnt0", bus.cnt_o, 0); chk("t1_zero0", bus.zero_o, 0); end
      if (t == 3) chk("t1_cnt3", bus.cnt_o, 3);
      if (t == 10) chk("t1_busy10", bus.busy_o, 1);
      if (t == 15) chk("t1_cnt15", bus.cnt_o, 15);
      if (t == 16) begin chk("t1_zero16", bus.zero_o, 1); chk("t1_ready16", bus.ready_o, 1); end
      if (t == 17) chk("t1_ready17", bus.ready_o, 0);
      if (t == 35) chk("t1_ready35", bus.ready_o, 0);
      if (t == 36) begin chk("t1_ready36", bus.ready_o, 1); chk("t1_cnt36", bus.cnt_o, 0); end
      if (t == 37) chk("t1_busy37", bus.busy_o, 0);
      step();
    end
    drained("t1_drained");

    // 2: three back-to-back frames
    base = cyc;
    for (int t = 0; t < 72; t++) begin
      bus.valid_i = (t <= 47);
      if (t == 0 || t == 16 || t == 32) push_frame(base + LAT + t, 16);
      @(negedge clk);
      if (t == 30) chk("t2_busy30", bus.busy_o, 1);
      if (t == 47) chk("t2_cnt47", bus.cnt_o, 15);
      if (t == 48) begin chk("t2_cnt48", bus.cnt_o, 0); chk("t2_zero48", bus.zero_o, 1); end
      if (t == 49) chk("t2_ready49", bus.ready_o, 0);
      if (t == 67) chk("t2_ready67", bus.ready_o, 0);
      if (t == 68) begin chk("t2_ready68", bus.ready_o, 1); chk("t2_cnt68", bus.cnt_o, 0); end
      step();
    end
    drained("t2_drained");

    // 3: short frame padded, then sticky error cleared
    base = cyc;
    for (int t = 0; t < 42; t++) begin
      bus.valid_i   = (t <= 4);
      bus.err_clr_i = (t == 40);
      if (t == 0) push_frame(base + LAT, 16);
      @(negedge clk);
      if (t == 4) chk("t3_zero4", bus.zero_o, 0);
      if (t == 5) begin chk("t3_zero5", bus.zero_o, 1); chk("t3_err5", bus.err_o, 0); end
      if (t == 6) begin
        chk("t3_err6", bus.err_o, 1);
        chk("t3_ready6", bus.ready_o, 0);
        chk("t3_cnt6", bus.cnt_o, 6);
      end
      if (t == 16) begin chk("t3_cnt16", bus.cnt_o, 0); chk("t3_ready16", bus.ready_o, 0); end
      if (t == 20) chk("t3_err20", bus.err_o, 1);
      if (t == 35) chk("t3_ready35", bus.ready_o, 0);
      if (t == 36) chk("t3_ready36", bus.ready_o, 1);
      if (t == 41) chk("t3_err_clr", bus.err_o, 0);
      step();
    end
    bus.err_clr_i = 1'b0;
    drained("t3_drained");

    // 4: valid held through drain, re-accepted only after return to idle
    base = cyc;
    for (int t = 0; t < 76; t++) begin
      bus.valid_i = (t <= 15) || (t >= 17 && t <= 51);
      if (t == 0 || t == 36) push_frame(base + LAT + t, 16);
      @(negedge clk);
      if (t == 25) begin chk("t4_ready25", bus.ready_o, 0); chk("t4_zero25", bus.zero_o, 1); end
      if (t == 35) chk("t4_zero35", bus.zero_o, 1);
      if (t == 36) begin
        chk("t4_ready36", bus.ready_o, 1);
        chk("t4_zero36", bus.zero_o, 0);
        chk("t4_cnt36", bus.cnt_o, 0);
      end
      if (t == 37) chk("t4_cnt37", bus.cnt_o, 1);
      if (t == 53) chk("t4_ready53", bus.ready_o, 0);
      if (t == 72) begin chk("t4_ready72", bus.ready_o, 1); chk("t4_cnt72", bus.cnt_o, 0); end
      step();
    end
    drained("t4_drained");

    // 5: reset mid-stream, then a fresh frame
    base = cyc;
    for (int t = 0; t < 70; t++) begin
      bus.valid_i = (t <= 24) || (t >= 30 && t <= 45);
      rst_n       = (t != 25);
      if (t == 0) push_frame(base + LAT, 6);
      if (t == 30) push_frame(base + 30 + LAT, 16);
      @(negedge clk);
      if (t == 26) begin
        chk("t5_valid26", bus.valid_o, 0);
        chk("t5_cnt26", bus.cnt_o, 0);
        chk("t5_busy26", bus.busy_o, 0);
        chk("t5_ready26", bus.ready_o, 1);
      end
      if (t == 31) chk("t5_cnt31", bus.cnt_o, 1);
      step();
    end
    rst_n = 1'b1;
    drained("t5_drained");

    // 6: en_i drop starts a pad; clear in the same cycle loses to the set
    base = cyc;
    for (int t = 0; t < 40; t++) begin
      bus.valid_i   = (t < 20);
      bus.en_i      = (t <= 2);
      bus.err_clr_i = (t == 3) || (t == 4);
      if (t == 0) push_frame(base + LAT, 16);
      @(negedge clk);
      if (t == 3) begin chk("t6_zero3", bus.zero_o, 1); chk("t6_err3", bus.err_o, 0); end
      if (t == 4) chk("t6_err4", bus.err_o, 1);
      if (t == 5) chk("t6_err5", bus.err_o, 0);
      if (t == 36) chk("t6_ready36", bus.ready_o, 1);
      step();
    end
    drained("t6_drained");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
